// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: round-robin sequencer for the shared ALU datapath.
// Two requesters (0 = execute, 1 = address/increment) share one ALU.
// The block drives the side-A/side-B operand mux selects, the immediate and the
// result demux, starts the ALU, waits for it with a timeout, then answers
// the requester that was served.
//
// Handshake: in IDLE, req_ready[n] is high when requester n holds a valid
// request and wins arbitration. The request is taken on a clock edge where
// req_valid[n] & req_ready[n] is 1. rsp_valid[n] is a one-cycle pulse, and
// rsp_err qualifies it. req_ready is combinational. Every other output is a
// register.
module alu_op_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [5:0]               req_src_a,
  input  logic [7:0]               req_src_b,
  input  logic [5:0]               req_dst,
  input  logic [1:0]               req_wb,
  input  logic [2*WORD_SIZE-1:0]   req_imm,
  output logic [2:0]               sel_a,
  output logic                     en_a,
  output logic [3:0]               sel_b,
  output logic                     en_b,
  output logic [WORD_SIZE-1:0]     imm_out,
  output logic [2:0]               sel_dst,
  output logic                     en_dst,
  output logic                     alu_start,
  input  logic                     alu_done,
  output logic [1:0]               rsp_valid,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPERAND   = 2'd1,
    EXEC      = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  state_t                 state, state_n;
  logic                   last, last_n;          // requester served most recently
  logic [2:0]             lat_src_a, lat_src_a_n;
  logic [3:0]             lat_src_b, lat_src_b_n;
  logic [2:0]             lat_dst, lat_dst_n;
  logic                   lat_wb, lat_wb_n;
  logic [WORD_SIZE-1:0]   lat_imm, lat_imm_n;
  logic                   lat_id, lat_id_n;
  logic                   err, err_n;
  logic [3:0]             cnt, cnt_n;

  logic                   gnt_any, gnt_id;
  logic [2:0]             g_src_a, g_dst;
  logic [3:0]             g_src_b;
  logic                   g_wb;
  logic [WORD_SIZE-1:0]   g_imm;

  logic                   en_ab_n, wb_phase_n;
  logic [2:0]             sel_a_n, sel_dst_n;
  logic [3:0]             sel_b_n;
  logic [WORD_SIZE-1:0]   imm_out_n;
  logic                   alu_start_n, en_dst_n, rsp_err_n;
  logic [1:0]             rsp_valid_n;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Arbitration: a lone requester wins. On a tie, the one not served last wins.
  // The fields of the winner are selected here.
  always_comb begin
    gnt_any = |req_valid;
    gnt_id  = (req_valid == 2'b11) ? ~last : req_valid[1];
    g_src_a = gnt_id ? req_src_a[5:3] : req_src_a[2:0];
    g_src_b = gnt_id ? req_src_b[7:4] : req_src_b[3:0];
    g_dst   = gnt_id ? req_dst[5:3]   : req_dst[2:0];
    g_wb    = gnt_id ? req_wb[1]      : req_wb[0];
    g_imm   = gnt_id ? req_imm[2*WORD_SIZE-1:WORD_SIZE] : req_imm[WORD_SIZE-1:0];
    req_ready = 2'b00;
    if (state == IDLE && gnt_any) req_ready = gnt_id ? 2'b10 : 2'b01;
  end

  // Next-state logic, request latching, and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    last_n      = last;
    lat_src_a_n = lat_src_a;
    lat_src_b_n = lat_src_b;
    lat_dst_n   = lat_dst;
    lat_wb_n    = lat_wb;
    lat_imm_n   = lat_imm;
    lat_id_n    = lat_id;
    err_n       = err;
    cnt_n       = cnt;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          lat_src_a_n = g_src_a;
          lat_src_b_n = g_src_b;
          lat_dst_n   = g_dst;
          lat_wb_n    = g_wb;
          lat_imm_n   = g_imm;
          lat_id_n    = gnt_id;
          last_n      = gnt_id;
          if (g_src_b <= 4'd8) begin
            state_n = OPERAND;
            err_n   = 1'b0;
          end else begin
            // An illegal side-B source skips the datapath and answers with an error.
            state_n = WRITEBACK;
            err_n   = 1'b1;
          end
        end
      end
      OPERAND: begin
        state_n = EXEC;
        cnt_n   = 4'd0;
      end
      EXEC: begin
        if (alu_done) begin
          state_n = WRITEBACK;
          err_n   = 1'b0;
        end else if (cnt == TO_CNT) begin
          state_n = WRITEBACK;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WRITEBACK: state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    en_ab_n     = (state_n == OPERAND) || (state_n == EXEC);
    wb_phase_n  = (state_n == WRITEBACK);
    sel_a_n     = en_ab_n ? lat_src_a_n : 3'd0;
    sel_b_n     = en_ab_n ? lat_src_b_n : 4'd0;
    imm_out_n   = en_ab_n ? lat_imm_n : '0;
    alu_start_n = (state == OPERAND);
    en_dst_n    = wb_phase_n & lat_wb_n & ~err_n;
    sel_dst_n   = wb_phase_n ? lat_dst_n : 3'd0;
    rsp_valid_n = wb_phase_n ? (lat_id_n ? 2'b10 : 2'b01) : 2'b00;
    rsp_err_n   = wb_phase_n & err_n;
  end

  // State, latched request, and registered outputs. Reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      lat_src_a <= 3'd0;
      lat_src_b <= 4'd0;
      lat_dst   <= 3'd0;
      lat_wb    <= 1'b0;
      lat_imm   <= '0;
      lat_id    <= 1'b0;
      err       <= 1'b0;
      cnt       <= 4'd0;
      en_a      <= 1'b0;
      en_b      <= 1'b0;
      sel_a     <= 3'd0;
      sel_b     <= 4'd0;
      imm_out   <= '0;
      alu_start <= 1'b0;
      en_dst    <= 1'b0;
      sel_dst   <= 3'd0;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      lat_src_a <= lat_src_a_n;
      lat_src_b <= lat_src_b_n;
      lat_dst   <= lat_dst_n;
      lat_wb    <= lat_wb_n;
      lat_imm   <= lat_imm_n;
      lat_id    <= lat_id_n;
      err       <= err_n;
      cnt       <= cnt_n;
      en_a      <= en_ab_n;
      en_b      <= en_ab_n;
      sel_a     <= sel_a_n;
      sel_b     <= sel_b_n;
      imm_out   <= imm_out_n;
      alu_start <= alu_start_n;
      en_dst    <= en_dst_n;
      sel_dst   <= sel_dst_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random operations, checked against a
// transaction-level timeline model of the sequencer.
module tb_alu_op_sequencer;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready;
  logic [5:0]     req_src_a, req_dst;
  logic [7:0]     req_src_b;
  logic [1:0]     req_wb;
  logic [2*W-1:0] req_imm;
  logic [2:0]     sel_a, sel_dst;
  logic [3:0]     sel_b;
  logic           en_a, en_b, en_dst, alu_start, alu_done, rsp_err, busy;
  logic [W-1:0]   imm_out;
  logic [1:0]     rsp_valid, state_dbg;

  int checks = 0;
  int errors = 0;
  int op_n   = 0;
  int mdl_last;                 // model: requester served most recently
  logic [27:0] exp_q[$];        // expected output vector, one entry per busy cycle
  logic [27:0] obs_vec;

  alu_op_sequencer #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
    .req_wb(req_wb), .req_imm(req_imm),
    .sel_a(sel_a), .en_a(en_a), .sel_b(sel_b), .en_b(en_b), .imm_out(imm_out),
    .sel_dst(sel_dst), .en_dst(en_dst), .alu_start(alu_start), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
  );

  assign obs_vec = {en_a, en_b, sel_a, sel_b, imm_out, alu_start, sel_dst, en_dst,
                    rsp_valid, rsp_err, busy, req_ready};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    req_src_a = 6'($urandom);
    req_src_b = 8'($urandom);
    req_dst   = 6'($urandom);
    req_wb    = 2'($urandom);
    req_imm   = 16'($urandom);
  endtask

  task automatic set_req(input int n, input int sa, input int sb, input int dst,
                         input int wb, input int imm);
    req_src_a[3*n +: 3] = 3'(sa);
    req_src_b[4*n +: 4] = 4'(sb);
    req_dst[3*n +: 3]   = 3'(dst);
    req_wb[n]           = 1'(wb);
    req_imm[W*n +: W]   = W'(imm);
  endtask

  task automatic set_rand(input int n);
    int sb;
    sb = ($urandom_range(0, 9) == 9) ? $urandom_range(9, 15) : $urandom_range(0, 8);
    set_req(n, $urandom_range(0, 7), sb, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 255));
  endtask

  // One operation. Entered #1 after a posedge while the DUT is idle, and returns
  // #1 after the posedge that brings it back to idle. dly >= 0 means alu_done
  // arrives dly cycles after alu_start. dly < 0 means alu_done never comes.
  task automatic do_op(input logic [1:0] mask, input int dly);
    int g, w;
    logic [2:0] sa, dst;
    logic [3:0] sb;
    logic wb, legal, err, en;
    logic [W-1:0] imm;
    logic [1:0] oh;
    req_valid = mask;
    alu_done  = 1'($urandom);
    g   = (mask == 2'b11) ? ((mdl_last == 0) ? 1 : 0) : (mask[1] ? 1 : 0);
    sa  = req_src_a[3*g +: 3];
    sb  = req_src_b[4*g +: 4];
    dst = req_dst[3*g +: 3];
    wb  = req_wb[g];
    imm = req_imm[W*g +: W];
    oh  = (g == 1) ? 2'b10 : 2'b01;
    legal = (sb <= 4'd8);
    err   = !legal || (dly < 0);
    w     = !legal ? 1 : ((dly < 0) ? TO + 3 : dly + 3);
    for (int k = 1; k <= w; k++) begin
      en = legal && (k <= w - 1);
      exp_q.push_back({en, en, en ? sa : 3'd0, en ? sb : 4'd0, en ? imm : 8'd0,
                       legal && (k == 2), (k == w) ? dst : 3'd0, (k == w) && wb && !err,
                       (k == w) ? oh : 2'b00, (k == w) && err, 1'b1, 2'b00});
    end
    op_n++;
    @(negedge clk);
    chk($sformatf("op%0d_accept", op_n), 32'(obs_vec), 32'({26'd0, oh}));
    mdl_last = g;
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      scramble();
      req_valid = 2'($urandom);
      if (legal && k >= 2 && k <= w - 1) alu_done = (dly >= 0) && (k == dly + 2);
      else                               alu_done = 1'($urandom);
      @(negedge clk);
      chk($sformatf("op%0d_c%0d", op_n, k), 32'(obs_vec), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    alu_done  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 2'b00;
      alu_done  = 1'($urandom);
      @(negedge clk);
      chk($sformatf("idle%0d", i), 32'(obs_vec), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    alu_done  = 1'b0;
    scramble();
    mdl_last = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'(obs_vec), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single op on requester 0
    set_req(0, 3, 5, 2, 1, 8'h11);
    do_op(2'b01, 2);
    // immediate operand on requester 1, no write-back
    set_req(1, 1, 8, 4, 0, 8'hA5);
    do_op(2'b10, 1);
    // both requesters valid back to back: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      set_req(0, $urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 7), 1, $urandom_range(0, 255));
      set_req(1, $urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 7), 1, $urandom_range(0, 255));
      do_op(2'b11, 0);
    end
    // illegal side-B source
    set_req(0, 2, 12, 5, 1, 8'h33);
    do_op(2'b01, 0);
    // timeout, then a normal op
    set_req(1, 4, 6, 1, 1, 8'h5A);
    do_op(2'b10, -1);
    set_req(0, 7, 0, 3, 1, 8'h00);
    do_op(2'b01, 1);

    // asynchronous reset in the middle of EXEC
    set_req(0, 6, 3, 7, 1, 8'h3C);
    req_valid = 2'b01;
    alu_done  = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs_vec), 32'd0);
    alu_done = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_last = 1;
    @(negedge clk);
    chk("late_done", 32'(obs_vec), 32'd0);
    @(posedge clk); #1;
    set_req(0, 1, 2, 3, 1, 8'h44);
    set_req(1, 5, 6, 7, 1, 8'h55);
    do_op(2'b11, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] mask;
      int dly;
      mask = 2'($urandom_range(1, 3));
      set_rand(0);
      set_rand(1);
      dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      do_op(mask, dly);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
